// File: rtl/binary_game_pkg.sv
// binary_game_pkg: shared debounce state encoding and parameter defaults for the binary_game front end.
package binary_game_pkg;
  typedef enum logic [1:0] {IDLE, PRESS_WAIT, HELD, RELEASE_WAIT} db_state_e;
  localparam int DEF_DEBOUNCE_CYCLES = 500000;
  localparam int DEF_REPEAT_DELAY    = 50000000;
  localparam int DEF_REPEAT_PERIOD   = 20000000;
  function automatic int max_int(input int a, input int b);
    return (a > b) ? a : b;
  endfunction
endpackage

// File: rtl/bg_debounce.sv
// bg_debounce: 2-flop synchronizer, press/release debounce FSM and combinational press pulse.
// Optional auto-repeat while held when BG_AUTOREPEAT_EN is defined.
module bg_debounce
  import binary_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BG_AUTOREPEAT_EN
  , parameter bit REPEAT_EN     = 1'b0,
  parameter int REPEAT_DELAY    = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic clk,
  input  logic rst,
  input  logic btn_i,
  output logic pulse_o
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  localparam logic [CW-1:0] MAX  = CW'(DEBOUNCE_CYCLES);
  logic [1:0] sync_q;
  db_state_e state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic lvl, press;
  assign lvl = sync_q[1];
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      sync_q  <= {sync_q[0], btn_i};
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end
  always_comb begin
    state_d = state_q;
    cnt_d   = (cnt_q == MAX) ? cnt_q : cnt_q + 1'b1;
    press   = 1'b0;
    case (state_q)
      IDLE: begin
        cnt_d = '0;
        if (lvl) state_d = PRESS_WAIT;
      end
      PRESS_WAIT:
        if (!lvl) begin
          state_d = IDLE;
          cnt_d   = '0;
        end else if (cnt_q == LAST) begin
          state_d = HELD;
          cnt_d   = '0;
          press   = 1'b1;
        end
      HELD: begin
        cnt_d = '0;
        if (!lvl) state_d = RELEASE_WAIT;
      end
      RELEASE_WAIT:
        if (lvl || cnt_q == LAST) begin
          state_d = lvl ? HELD : IDLE;
          cnt_d   = '0;
        end
      default: state_d = IDLE;
    endcase
  end
`ifdef BG_AUTOREPEAT_EN
  localparam int RW = $clog2(max_int(REPEAT_DELAY, REPEAT_PERIOD) + 1);
  logic [RW-1:0] rcnt_q, rcnt_d, rlim;
  logic rfirst_q, rfirst_d, rep;
  // first repeat waits REPEAT_DELAY, later ones REPEAT_PERIOD
  assign rlim = rfirst_q ? RW'(REPEAT_PERIOD - 1) : RW'(REPEAT_DELAY - 1);
  always_comb begin
    rep      = REPEAT_EN && state_q == HELD && lvl && rcnt_q == rlim;
    rcnt_d   = (!REPEAT_EN || state_q != HELD || rep) ? '0 : rcnt_q + 1'b1;
    rfirst_d = (state_q == IDLE) ? 1'b0 : (rfirst_q | rep);
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      rcnt_q   <= '0;
      rfirst_q <= 1'b0;
    end else begin
      rcnt_q   <= rcnt_d;
      rfirst_q <= rfirst_d;
    end
  end
  assign pulse_o = press | rep;
`else
  assign pulse_o = press;
`endif
endmodule

// File: rtl/binary_game_input_conditioner.sv
// binary_game_input_conditioner: debounced button pulses with conflict resolution and debounced switches.
// Auto-repeat of left/right is enabled by defining BG_AUTOREPEAT_EN.
module binary_game_input_conditioner
  import binary_game_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEF_DEBOUNCE_CYCLES
`ifdef BG_AUTOREPEAT_EN
  , parameter int REPEAT_DELAY  = DEF_REPEAT_DELAY,
  parameter int REPEAT_PERIOD   = DEF_REPEAT_PERIOD
`endif
) (
  input  logic       Clk,
  input  logic       Reset,
  input  logic       btnSelect,
  input  logic       btnQuit,
  input  logic       btnLeft,
  input  logic       btnRight,
  input  logic [7:0] swNumber,
  output logic       Select,
  output logic       Quit,
  output logic       selectLeft,
  output logic       selectRight,
  output logic [7:0] userNumber,
  output logic       numberChanged
);
  localparam int CW = $clog2(DEBOUNCE_CYCLES + 1);
  localparam logic [CW-1:0] LAST = CW'(DEBOUNCE_CYCLES - 1);
  logic [3:0] btns, raw, pulse_d, pulse_q;
  logic [7:0] sw1_q, sw2_q, cand_q, num_q;
  logic [CW-1:0] scnt_q;
  logic chg_q, stable, upd, lr_ok;
  // bit order {quit, select, left, right}; only left/right may repeat
  assign btns = {btnQuit, btnSelect, btnLeft, btnRight};
  for (genvar i = 0; i < 4; i++) begin : g_btn
    bg_debounce #(
      .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
`ifdef BG_AUTOREPEAT_EN
      , .REPEAT_EN(i < 2),
      .REPEAT_DELAY(REPEAT_DELAY),
      .REPEAT_PERIOD(REPEAT_PERIOD)
`endif
    ) u_db (
      .clk    (Clk),
      .rst    (Reset),
      .btn_i  (btns[i]),
      .pulse_o(raw[i])
    );
  end
  assign lr_ok   = ~raw[3] & ~raw[2] & ~(raw[1] & raw[0]);
  assign pulse_d = {raw[3], raw[2] & ~raw[3], raw[1] & lr_ok, raw[0] & lr_ok};
  assign stable  = sw2_q == cand_q;
  assign upd     = stable && scnt_q >= LAST && cand_q != num_q;
  always_ff @(posedge Clk) begin
    if (Reset) begin
      sw1_q   <= '0;
      sw2_q   <= '0;
      cand_q  <= '0;
      scnt_q  <= '0;
      num_q   <= '0;
      chg_q   <= 1'b0;
      pulse_q <= '0;
    end else begin
      sw1_q   <= swNumber;
      sw2_q   <= sw1_q;
      cand_q  <= sw2_q;
      scnt_q  <= !stable ? '0 : (scnt_q >= LAST ? scnt_q : scnt_q + 1'b1);
      num_q   <= upd ? cand_q : num_q;
      chg_q   <= upd;
      pulse_q <= pulse_d;
    end
  end
  assign {Quit, Select, selectLeft, selectRight} = pulse_q;
  assign userNumber    = num_q;
  assign numberChanged = chg_q;
endmodule

// File: tb/tb_binary_game_input_conditioner.sv
// tb_binary_game_input_conditioner: directed scoreboard bench for the input conditioner (DEBOUNCE_CYCLES=4).
module tb_binary_game_input_conditioner;
  logic Clk = 1'b0, Reset = 1'b1;
  logic btnSelect = 1'b0, btnQuit = 1'b0, btnLeft = 1'b0, btnRight = 1'b0;
  logic [7:0] swNumber = 8'h00;
  logic Select, Quit, selectLeft, selectRight, numberChanged;
  logic [7:0] userNumber;

  typedef struct {
    int         cyc;
    logic [3:0] p;
    logic       nv;
    logic [7:0] num;
  } exp_t;
  exp_t sb[$];
  int cyc = 0, checks = 0, errors = 0;
  logic [7:0] exp_num = 8'h00;
  string tag = "reset";

  binary_game_input_conditioner #(
    .DEBOUNCE_CYCLES(4)
`ifdef BG_AUTOREPEAT_EN
    , .REPEAT_DELAY(20),
    .REPEAT_PERIOD(8)
`endif
  ) dut (
    .Clk(Clk), .Reset(Reset),
    .btnSelect(btnSelect), .btnQuit(btnQuit), .btnLeft(btnLeft), .btnRight(btnRight),
    .swNumber(swNumber),
    .Select(Select), .Quit(Quit), .selectLeft(selectLeft), .selectRight(selectRight),
    .userNumber(userNumber), .numberChanged(numberChanged)
  );

  always #5 Clk = ~Clk;

  function automatic void push(input int c, input logic [3:0] p, input logic nv, input logic [7:0] num);
    exp_t e;
    e.cyc = c; e.p = p; e.nv = nv; e.num = num;
    sb.push_back(e);
  endfunction

  task automatic tick();
    logic r;
    logic [3:0] exp_p;
    logic exp_c;
    exp_t e;
    r = Reset;
    @(posedge Clk);
    #1;
    cyc++;
    exp_p = '0;
    exp_c = 1'b0;
    if (r) exp_num = 8'h00;
    while (sb.size() > 0 && sb[0].cyc == cyc) begin
      e = sb.pop_front();
      exp_p |= e.p;
      if (e.nv) begin
        exp_c   = e.num != exp_num;
        exp_num = e.num;
      end
    end
    checks++;
    assert ({Quit, Select, selectLeft, selectRight, numberChanged, userNumber} === {exp_p, exp_c, exp_num})
    else begin
      errors++;
      $error("FAIL %s cyc=%0d: got Q/S/L/R=%b chg=%b num=%h, expected Q/S/L/R=%b chg=%b num=%h",
             tag, cyc, {Quit, Select, selectLeft, selectRight}, numberChanged, userNumber,
             exp_p, exp_c, exp_num);
    end
  endtask

  task automatic hold(input int n);
    for (int i = 0; i < n; i++) tick();
  endtask

  initial begin
    int c;
    hold(3);
    Reset = 1'b0;
    hold(3);

    tag = "clean_press";
    btnSelect = 1'b1; push(cyc + 7, 4'b0100, 1'b0, 8'h00);
    hold(30); btnSelect = 1'b0; hold(20);

    tag = "glitch";
    btnLeft = 1'b1; hold(3); btnLeft = 1'b0; hold(12);
    tag = "left_after_glitch";
    btnLeft = 1'b1; push(cyc + 7, 4'b0010, 1'b0, 8'h00);
    hold(10); btnLeft = 1'b0; hold(15);

    tag = "quit_select";
    btnQuit = 1'b1; btnSelect = 1'b1; push(cyc + 7, 4'b1000, 1'b0, 8'h00);
    hold(10); btnQuit = 1'b0; btnSelect = 1'b0; hold(15);

    tag = "select_left";
    btnSelect = 1'b1; btnLeft = 1'b1; push(cyc + 7, 4'b0100, 1'b0, 8'h00);
    hold(10); btnSelect = 1'b0; btnLeft = 1'b0; hold(15);

    tag = "left_right";
    btnLeft = 1'b1; btnRight = 1'b1;
    hold(10); btnLeft = 1'b0; btnRight = 1'b0; hold(15);

    tag = "switch_bounce";
    swNumber = 8'hA5; hold(1);
    swNumber = 8'h25; hold(2);
    swNumber = 8'hA5; push(cyc + 7, 4'b0000, 1'b1, 8'hA5);
    hold(15);

    tag = "reset_mid_debounce";
    btnRight = 1'b1; hold(2);
    Reset = 1'b1; hold(2);
    Reset = 1'b0; push(cyc + 7, 4'b0001, 1'b1, 8'hA5);
    hold(20); btnRight = 1'b0; hold(15);

    tag = "right_held";
    c = cyc;
    btnRight = 1'b1; push(c + 7, 4'b0001, 1'b0, 8'h00);
`ifdef BG_AUTOREPEAT_EN
    for (int i = 0; i < 4; i++) push(c + 27 + 8 * i, 4'b0001, 1'b0, 8'h00);
`endif
    hold(50); btnRight = 1'b0; hold(20);

    tag = "scoreboard_drained";
    checks++;
    assert (sb.size() == 0)
    else begin
      errors++;
      $error("FAIL %s: %0d expected events still pending, required 0", tag, sb.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
